// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver that turns serial frames into a data word with a one-cycle done strobe
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done_tick,
    output logic                 o_frame_err
);
    localparam int SW = (SB_TICKS > 16) ? $clog2(SB_TICKS) : 4;
    localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_BIT  = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               r_state, w_state;
    logic [SW-1:0]        r_s, w_s;
    logic [NW-1:0]        r_n, w_n;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic [DATA_BITS-1:0] r_data, w_data;
    logic                 r_err, w_err;
    logic                 r_done, w_done;
    logic [1:0]           r_sync;
    logic                 w_rx_s;
    logic [DATA_BITS:0]   w_shift_in;

    assign w_rx_s         = r_sync[1];
    assign w_shift_in     = {w_rx_s, r_shift};
    assign o_data         = r_data;
    assign o_rx_done_tick = r_done;
    assign o_frame_err    = r_err;

    // State, counters, synchronizer and output registers; reset parks everything at idle-line values
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_sync  <= 2'b11;
        end else begin
            r_state <= w_state;
            r_s     <= w_s;
            r_n     <= w_n;
            r_shift <= w_shift;
            r_data  <= w_data;
            r_err   <= w_err;
            r_done  <= w_done;
            r_sync  <= {r_sync[0], i_rx};
        end
    end

    // Next-state logic: counters only move on tick cycles; IDLE reacts to the line immediately
    always_comb begin
        w_state = r_state;
        w_s     = r_s;
        w_n     = r_n;
        w_shift = r_shift;
        w_data  = r_data;
        w_err   = r_err;
        w_done  = 1'b0;
        case (r_state)
            IDLE: if (!w_rx_s) begin
                w_state = START;
                w_s     = '0;
            end
            START: if (i_tick) begin
                if (r_s == S_MID) begin
                    w_state = w_rx_s ? IDLE : DATA;
                    w_s     = '0;
                    w_n     = '0;
                end else w_s = r_s + 1'b1;
            end
            DATA: if (i_tick) begin
                if (r_s == S_BIT) begin
                    w_s     = '0;
                    w_shift = w_shift_in[DATA_BITS:1];
                    if (r_n == N_LAST) w_state = STOP;
                    else w_n = r_n + 1'b1;
                end else w_s = r_s + 1'b1;
            end
            STOP: if (i_tick) begin
                if (r_s == S_STOP) begin
                    w_state = IDLE;
                    w_data  = r_shift;
                    w_err   = ~w_rx_s;
                    w_done  = 1'b1;
                end else w_s = r_s + 1'b1;
            end
            default: w_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against a queue-based frame model
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       i_reset, i_tick, i_rx;
    logic [7:0] o_data;
    logic       o_rx_done_tick, o_frame_err;
    logic [1:0] ph = 2'd0;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_d[$];
    logic       exp_e[$];
    logic [7:0] got_d[$];
    logic       got_e[$];
    logic [7:0] last_data = 8'h00;
    logic       last_err = 1'b0;

    uart_rx #(.DATA_BITS(8), .SB_TICKS(16)) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_tick(i_tick),
        .i_rx(i_rx),
        .o_data(o_data),
        .o_rx_done_tick(o_rx_done_tick),
        .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    // One tick every four clocks: one bit time is 64 clocks
    always @(posedge clk) ph <= ph + 2'd1;
    assign i_tick = (ph == 2'd3);

    // Record every cycle where done is high; a stretched pulse shows up as extra entries
    always @(negedge clk) if (o_rx_done_tick) begin
        got_d.push_back(o_data);
        got_e.push_back(o_frame_err);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b, input int n);
        i_rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic good);
        drive(1'b0, 64);
        for (int i = 0; i < 8; i++) drive(d[i], 64);
        if (good) drive(1'b1, 64);
        else begin
            drive(1'b0, 48);
            drive(1'b1, 16);
        end
        exp_d.push_back(d);
        exp_e.push_back(!good);
        last_data = d;
        last_err  = !good;
    endtask

    task automatic verify(input string tag);
        chk({tag, "_count"}, got_d.size(), exp_d.size());
        while (exp_d.size() > 0 && got_d.size() > 0) begin
            chk({tag, "_data"}, got_d.pop_front(), exp_d.pop_front());
            chk({tag, "_err"}, got_e.pop_front(), exp_e.pop_front());
        end
        chk({tag, "_held_data"}, o_data, last_data);
        chk({tag, "_held_err"}, o_frame_err, last_err);
        got_d.delete(); got_e.delete(); exp_d.delete(); exp_e.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       good;
        i_rx = 1'b1;
        i_reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_data", o_data, 0);
        chk("reset_err", o_frame_err, 0);
        chk("reset_done", o_rx_done_tick, 0);
        i_reset = 1'b0;
        drive(1'b1, 200);
        verify("idle");

        send_frame(8'h55, 1'b1);
        drive(1'b1, 80);
        verify("x55");

        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        drive(1'b1, 80);
        verify("b2b");

        drive(1'b0, 12);
        drive(1'b1, 200);
        verify("glitch");

        send_frame(8'hC6, 1'b0);
        drive(1'b1, 80);
        verify("stop_err");
        send_frame(8'h12, 1'b1);
        drive(1'b1, 80);
        verify("err_clear");

        drive(1'b0, 64);
        for (int i = 0; i < 4; i++) drive(1'b1, 64);
        drive(1'b1, 32);
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreset_data", o_data, 0);
        chk("midreset_err", o_frame_err, 0);
        chk("midreset_done", o_rx_done_tick, 0);
        i_reset = 1'b0;
        last_data = 8'h00;
        last_err = 1'b0;
        drive(1'b1, 400);
        verify("aborted");
        send_frame(8'h81, 1'b1);
        drive(1'b1, 80);
        verify("after_reset");

        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            send_frame(d, good);
            drive(1'b1, good ? $urandom_range(0, 80) : $urandom_range(48, 80));
        end
        drive(1'b1, 80);
        verify("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
